// File: rtl/sudoku_grid_checker_if.sv
// ----------------------------------------------------------------------------
// sudoku_grid_checker_if
// Bundles the checker's RAM read port, scan request and result signals.
//   start          scan request (rising edge starts a scan)
//   RAM_ceb        RAM access enable, RAM_web write enable (always read)
//   RAM_A / RAM_Q  read address / read data (data one cycle after access)
//   busy, valid, pass, err_cnt, first_err_addr, timeout   scan results
// Modports: master = checker side, slave = RAM / controller side.
// ----------------------------------------------------------------------------
interface sudoku_grid_checker_if #(
   parameter int DW = 8,
   parameter int AW = 7,
   parameter int EW = 7
);
   logic          start;
   logic          RAM_ceb;
   logic          RAM_web;
   logic [AW-1:0] RAM_A;
   logic [DW-1:0] RAM_Q;
   logic          busy;
   logic          valid;
   logic          pass;
   logic [EW-1:0] err_cnt;
   logic [AW-1:0] first_err_addr;
   logic          timeout;

   modport master (
      input  start, RAM_Q,
      output RAM_ceb, RAM_web, RAM_A, busy, valid, pass, err_cnt,
             first_err_addr, timeout
   );

   modport slave (
      output start, RAM_Q,
      input  RAM_ceb, RAM_web, RAM_A, busy, valid, pass, err_cnt,
             first_err_addr, timeout
   );
endinterface

// File: rtl/sudoku_grid_checker.sv
// ----------------------------------------------------------------------------
// sudoku_grid_checker
// Scans a BOX*BOX Sudoku result RAM (row-major, CELLS = N*N entries) after a
// start edge and reports whether every cell is legal (1..N) and unique in its
// row, column and box. Also runs a watchdog that flags a timeout if no start
// ever arrives after reset.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high
//   bus   sudoku_grid_checker_if.master (start, RAM port, result outputs)
// ----------------------------------------------------------------------------
module sudoku_grid_checker #(
   parameter int BOX       = 3,
   parameter int DW        = 8,
   parameter int AW        = 7,
   parameter int MAX_CYCLE = 10000
) (
   input logic                    clk,
   input logic                    rst,
   sudoku_grid_checker_if.master  bus
);

   localparam int N     = BOX * BOX;
   localparam int CELLS = N * N;
   localparam int EW    = $clog2(CELLS + 1);
   localparam int NW    = (N > 1) ? $clog2(N) : 1;
   localparam int BW    = (BOX > 1) ? $clog2(BOX) : 1;
   localparam int WW    = $clog2(MAX_CYCLE + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t        state;
   logic          start_q;
   logic [WW-1:0] wd_cnt;
   logic          wd_stop;
   logic          timeout_r;
   logic          busy_r;
   logic          valid_r;
   logic          pass_r;

   logic          vld_p0;
   logic [AW-1:0] addr_p0;
   logic [NW-1:0] col_p0;
   logic [BW-1:0] rb_p0;   // row within the current band of boxes
   logic [BW-1:0] cb_p0;   // column within the current box
   logic [BW-1:0] bx_p0;   // box column index

   logic          vld_p1;
   logic [AW-1:0] addr_p1;
   logic [NW-1:0] col_p1;
   logic [BW-1:0] rb_p1;
   logic [BW-1:0] bx_p1;

   logic [N-1:0]            row_mask;
   logic [N-1:0][N-1:0]     col_mask;
   logic [BOX-1:0][N-1:0]   box_mask;
   logic [EW-1:0]           err_cnt_r;
   logic [AW-1:0]           first_err_r;

   logic          accept;
   logic [DW-1:0] v;
   logic          legal;
   logic [N-1:0]  vbit;
   logic          row_clr;
   logic          box_clr;
   logic [N-1:0]  eff_row;
   logic [N-1:0]  eff_box;
   logic          dup;
   logic          offend;

   function automatic logic [EW-1:0] sat_inc(input logic [EW-1:0] x);
      return (x == EW'(CELLS)) ? x : x + EW'(1);
   endfunction

   assign accept = (state == IDLE) && bus.start && !start_q;

   // ---- p0: issue stage, FSM, address generation and watchdog ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         start_q   <= 1'b0;
         wd_cnt    <= '0;
         wd_stop   <= 1'b0;
         timeout_r <= 1'b0;
         busy_r    <= 1'b0;
         valid_r   <= 1'b0;
         pass_r    <= 1'b0;
         vld_p0    <= 1'b0;
         addr_p0   <= '0;
         col_p0    <= '0;
         rb_p0     <= '0;
         cb_p0     <= '0;
         bx_p0     <= '0;
      end else begin
         start_q <= bus.start;
         case (state)
            IDLE: begin
               if (accept) begin
                  state   <= ISSUE;
                  wd_stop <= 1'b1;
                  busy_r  <= 1'b1;
                  valid_r <= 1'b0;
                  pass_r  <= 1'b0;
                  vld_p0  <= 1'b1;
                  addr_p0 <= '0;
                  col_p0  <= '0;
                  rb_p0   <= '0;
                  cb_p0   <= '0;
                  bx_p0   <= '0;
               end else if (!wd_stop && !timeout_r) begin
                  // The watchdog can only run before the first start, and the
                  // FSM is necessarily idle throughout that window.
                  if (wd_cnt == WW'(MAX_CYCLE - 1)) begin
                     timeout_r <= 1'b1;
                     valid_r   <= 1'b1;
                     pass_r    <= 1'b0;
                  end else begin
                     wd_cnt <= wd_cnt + WW'(1);
                  end
               end
            end
            ISSUE: begin
               if (addr_p0 == AW'(CELLS - 1)) begin
                  vld_p0 <= 1'b0;
                  state  <= DRAIN;
               end else begin
                  addr_p0 <= addr_p0 + AW'(1);
                  if (col_p0 == NW'(N - 1)) begin
                     col_p0 <= '0;
                     cb_p0  <= '0;
                     bx_p0  <= '0;
                     rb_p0  <= (rb_p0 == BW'(BOX - 1)) ? '0 : rb_p0 + BW'(1);
                  end else begin
                     col_p0 <= col_p0 + NW'(1);
                     if (cb_p0 == BW'(BOX - 1)) begin
                        cb_p0 <= '0;
                        bx_p0 <= bx_p0 + BW'(1);
                     end else begin
                        cb_p0 <= cb_p0 + BW'(1);
                     end
                  end
               end
            end
            DRAIN: state <= DONE;
            DONE: begin
               state   <= IDLE;
               busy_r  <= 1'b0;
               valid_r <= 1'b1;
               pass_r  <= (err_cnt_r == '0) && !timeout_r;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---- p1: check stage, RAM_Q belongs to the cell issued last cycle ----
   always_comb begin
      v       = bus.RAM_Q;
      legal   = (v != '0) && (v <= DW'(N));
      vbit    = '0;
      for (int i = 0; i < N; i++) begin
         vbit[i] = legal && (v == DW'(i + 1));
      end
      row_clr = (col_p1 == '0);
      box_clr = row_clr && (rb_p1 == '0);
      eff_row = row_clr ? '0 : row_mask;
      eff_box = box_clr ? '0 : box_mask[bx_p1];
      // vbit is zero for an illegal value, so such a cell never collides and
      // never adds to a mask, while the row/box clears still take effect.
      dup     = |(vbit & (eff_row | col_mask[col_p1] | eff_box));
      offend  = vld_p1 && (!legal || dup);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         addr_p1     <= '0;
         col_p1      <= '0;
         rb_p1       <= '0;
         bx_p1       <= '0;
         row_mask    <= '0;
         col_mask    <= '0;
         box_mask    <= '0;
         err_cnt_r   <= '0;
         first_err_r <= '0;
      end else begin
         vld_p1  <= vld_p0;
         addr_p1 <= addr_p0;
         col_p1  <= col_p0;
         rb_p1   <= rb_p0;
         bx_p1   <= bx_p0;
         if (accept) begin
            row_mask    <= '0;
            col_mask    <= '0;
            box_mask    <= '0;
            err_cnt_r   <= '0;
            first_err_r <= '0;
         end else if (vld_p1) begin
            row_mask         <= eff_row | vbit;
            col_mask[col_p1] <= col_mask[col_p1] | vbit;
            for (int b = 0; b < BOX; b++) begin
               if (BW'(b) == bx_p1) begin
                  box_mask[b] <= eff_box | vbit;
               end else if (box_clr) begin
                  box_mask[b] <= '0;
               end
            end
            if (offend) begin
               err_cnt_r <= sat_inc(err_cnt_r);
               if (err_cnt_r == '0) begin
                  first_err_r <= addr_p1;
               end
            end
         end
      end
   end

   assign bus.RAM_ceb        = vld_p0;
   assign bus.RAM_web        = 1'b1;
   assign bus.RAM_A          = addr_p0;
   assign bus.busy           = busy_r;
   assign bus.valid          = valid_r;
   assign bus.pass           = pass_r;
   assign bus.err_cnt        = err_cnt_r;
   assign bus.first_err_addr = first_err_r;
   assign bus.timeout        = timeout_r;

endmodule

// File: tb/tb_sudoku_grid_checker.sv
// ----------------------------------------------------------------------------
// tb_sudoku_grid_checker
// Two checker instances (9x9 and 4x4) on behavioural RAMs. Stimulus pushes
// expected results into per-instance queues; monitors pop and compare on each
// rising edge of valid. Expected results come from a rule-level model: a cell
// offends if illegal or if an earlier legal cell in its row, column or box
// holds the same value.
// ----------------------------------------------------------------------------
module tb_sudoku_grid_checker;

   localparam int MAXC = 10000;

   typedef struct {
      int pass;
      int err;
      int first;
      int tmo;
      int ceb;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   grid [128];
   exp_t q1 [$];
   exp_t q2 [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sudoku_grid_checker_if #(.DW(8), .AW(7), .EW(7)) if1 ();
   sudoku_grid_checker_if #(.DW(8), .AW(4), .EW(5)) if2 ();

   sudoku_grid_checker #(.BOX(3), .DW(8), .AW(7), .MAX_CYCLE(MAXC)) dut1 (
      .clk(clk), .rst(rst), .bus(if1.master));
   sudoku_grid_checker #(.BOX(2), .DW(8), .AW(4), .MAX_CYCLE(MAXC)) dut2 (
      .clk(clk), .rst(rst), .bus(if2.master));

   // Behavioural RAMs: one-cycle read latency.
   always @(posedge clk) if (if1.RAM_ceb) if1.RAM_Q <= 8'(grid[if1.RAM_A]);
   always @(posedge clk) if (if2.RAM_ceb) if2.RAM_Q <= 8'(grid[if2.RAM_A]);

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model(input int box, output int err, output int first);
      int n = box * box;
      int cells = n * n;
      bit found = 0;
      err = 0;
      first = 0;
      for (int a = 0; a < cells; a++) begin
         int r = a / n;
         int c = a % n;
         bit bad = (grid[a] < 1) || (grid[a] > n);
         if (!bad) begin
            for (int b = 0; b < a; b++) begin
               int r2 = b / n;
               int c2 = b % n;
               if (grid[b] == grid[a] &&
                   (r2 == r || c2 == c || (r2 / box == r / box && c2 / box == c / box)))
                  bad = 1;
            end
         end
         if (bad) begin
            if (!found) begin
               first = a;
               found = 1;
            end
            if (err < cells) err++;
         end
      end
   endfunction

   task automatic good_grid(input int box, input bit shuffle);
      int n = box * box;
      int perm [9];
      for (int i = 0; i < 128; i++) grid[i] = 0;
      for (int i = 0; i < n; i++) perm[i] = i + 1;
      if (shuffle) begin
         for (int i = n - 1; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
         end
      end
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            grid[r * n + c] = perm[(r * box + r / box + c) % n];
   endtask

   // ---- monitors ----
   logic v1_prev = 1'b0, v2_prev = 1'b0;
   logic web1_bad = 1'b0, web2_bad = 1'b0;
   int   ceb1 = 0, ceb2 = 0;
   exp_t e1, e2;

   always @(negedge clk) begin
      if (rst) begin
         v1_prev <= 1'b0;
         ceb1    <= 0;
      end else begin
         if (if1.RAM_web !== 1'b1) web1_bad <= 1'b1;
         ceb1 <= ceb1 + (if1.RAM_ceb ? 1 : 0);
         if (if1.valid && !v1_prev) begin
            if (q1.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL d1_unexpected_valid: valid rose with no scan pending (cycle %0d)", cyc);
            end else begin
               e1 = q1.pop_front();
               chk("d1_pass", int'(if1.pass), e1.pass);
               chk("d1_err_cnt", int'(if1.err_cnt), e1.err);
               chk("d1_first_err_addr", int'(if1.first_err_addr), e1.first);
               chk("d1_timeout", int'(if1.timeout), e1.tmo);
               chk("d1_busy_at_valid", int'(if1.busy), 0);
               chk("d1_ceb_cycles", ceb1, e1.ceb);
               chk("d1_latency_cycle", cyc, e1.cyc);
               chk("d1_web_high", int'(web1_bad), 0);
            end
            ceb1 <= 0;
         end
         v1_prev <= if1.valid;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         v2_prev <= 1'b0;
         ceb2    <= 0;
      end else begin
         if (if2.RAM_web !== 1'b1) web2_bad <= 1'b1;
         ceb2 <= ceb2 + (if2.RAM_ceb ? 1 : 0);
         if (if2.valid && !v2_prev) begin
            if (q2.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL d2_unexpected_valid: valid rose with no scan pending (cycle %0d)", cyc);
            end else begin
               e2 = q2.pop_front();
               chk("d2_pass", int'(if2.pass), e2.pass);
               chk("d2_err_cnt", int'(if2.err_cnt), e2.err);
               chk("d2_first_err_addr", int'(if2.first_err_addr), e2.first);
               chk("d2_timeout", int'(if2.timeout), e2.tmo);
               chk("d2_busy_at_valid", int'(if2.busy), 0);
               chk("d2_ceb_cycles", ceb2, e2.ceb);
               chk("d2_latency_cycle", cyc, e2.cyc);
               chk("d2_web_high", int'(web2_bad), 0);
            end
            ceb2 <= 0;
         end
         v2_prev <= if2.valid;
      end
   end

   // ---- stimulus ----
   task automatic wait_q(input int d, input int bound);
      int k = 0;
      while ((d == 1 ? q1.size() : q2.size()) != 0 && k < bound) begin
         @(posedge clk);
         k++;
      end
      if ((d == 1 ? q1.size() : q2.size()) != 0) begin
         tests++;
         fails++;
         $display("FAIL d%0d_result_wait: no valid within %0d cycles", d, bound);
         if (d == 1) q1.delete(); else q2.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic run(input int d, input int tmo, input int hold);
      int box = (d == 1) ? 3 : 2;
      int n = box * box;
      int err, first;
      exp_t e;
      model(box, err, first);
      e.pass  = (err == 0 && tmo == 0) ? 1 : 0;
      e.err   = err;
      e.first = first;
      e.tmo   = tmo;
      e.ceb   = n * n;
      @(posedge clk);
      #1;
      e.cyc = cyc + 1 + n * n + 2;
      if (d == 1) begin
         q1.push_back(e);
         if1.start = 1'b1;
      end else begin
         q2.push_back(e);
         if2.start = 1'b1;
      end
      repeat (hold) @(posedge clk);
      #1;
      if1.start = 1'b0;
      if2.start = 1'b0;
      wait_q(d, 300);
   endtask

   task automatic corrupt(input int cells, input int k, input int maxv);
      for (int i = 0; i < k; i++) grid[$urandom_range(0, cells - 1)] = $urandom_range(0, maxv);
   endtask

   initial begin
      exp_t et;
      if1.start = 1'b0;
      if2.start = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ceb", int'(if1.RAM_ceb), 0);
      chk("rst_web", int'(if1.RAM_web), 1);
      chk("rst_addr", int'(if1.RAM_A), 0);
      chk("rst_busy", int'(if1.busy), 0);
      chk("rst_valid", int'(if1.valid), 0);
      chk("rst_pass", int'(if1.pass), 0);
      chk("rst_err_cnt", int'(if1.err_cnt), 0);
      chk("rst_first", int'(if1.first_err_addr), 0);
      chk("rst_timeout", int'(if1.timeout), 0);
      chk("rst_d2_valid", int'(if2.valid), 0);
      rst = 1'b0;
      et = '{pass: 0, err: 0, first: 0, tmo: 1, ceb: 0, cyc: cyc + MAXC};
      q1.push_back(et);

      // 4x4 instance: good grid, all-ones, all-zeros, random, held start
      good_grid(2, 0);
      run(2, 0, 1);
      for (int i = 0; i < 16; i++) grid[i] = 1;
      run(2, 0, 1);
      for (int i = 0; i < 16; i++) grid[i] = 0;
      run(2, 0, 1);
      for (int t = 0; t < 4; t++) begin
         good_grid(2, 1);
         corrupt(16, $urandom_range(0, 3), 6);
         run(2, 0, 1);
      end
      good_grid(2, 1);
      run(2, 0, 50);
      repeat (25) @(posedge clk);
      #1;

      // 9x9 watchdog: no start since reset
      wait_q(1, MAXC + 100);
      chk("tmo_busy", int'(if1.busy), 0);
      chk("tmo_state_valid_held", int'(if1.valid), 1);
      good_grid(3, 0);
      run(1, 1, 1);
      corrupt(81, 2, 12);
      run(1, 1, 1);

      // fresh reset, functional scans
      @(posedge clk);
      #1;
      rst = 1'b1;
      q1.delete();
      q2.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      good_grid(3, 0);
      run(1, 0, 1);
      begin
         int t = grid[0];
         grid[0] = grid[1];
         grid[1] = t;
      end
      run(1, 0, 1);
      good_grid(3, 0);
      grid[40] = 0;
      grid[80] = 10;
      run(1, 0, 1);
      for (int i = 0; i < 81; i++) grid[i] = 0;
      run(1, 0, 1);
      for (int t = 0; t < 8; t++) begin
         good_grid(3, 1);
         corrupt(81, $urandom_range(0, 4), 11);
         run(1, 0, 1);
      end
      for (int i = 0; i < 81; i++) grid[i] = $urandom_range(1, 9);
      run(1, 0, 1);

      // reset in the middle of a scan
      good_grid(3, 1);
      @(posedge clk);
      #1;
      if1.start = 1'b1;
      @(posedge clk);
      #1;
      if1.start = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("midscan_busy_before_rst", int'(if1.busy), 1);
      rst = 1'b1;
      #1;
      chk("midscan_rst_ceb", int'(if1.RAM_ceb), 0);
      chk("midscan_rst_busy", int'(if1.busy), 0);
      chk("midscan_rst_valid", int'(if1.valid), 0);
      chk("midscan_rst_err_cnt", int'(if1.err_cnt), 0);
      chk("midscan_rst_addr", int'(if1.RAM_A), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      run(1, 0, 1);

      chk("q1_empty_at_end", q1.size(), 0);
      chk("q2_empty_at_end", q2.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
